// File: rtl/uart_pkg.sv
// Shared definitions for the command UART: receiver state encoding and the
// standard divider for 19200 baud at 50 MHz.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int unsigned BAUD_DIV_19200 = 2604;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input. The reset value
// is a parameter so idle-high and idle-low lines can both be brought in
// without a spurious edge at reset release.
module rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= RESET_VAL;
      sync_out <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments make both stages sample the old value
      // on the same edge; blocking ones would collapse the chain to one flop.
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Detects a start edge on the synchronized line, samples
// each bit at mid-bit with a down-counting baud timer, and presents the byte
// with a ready flag held until the consumer acknowledges it. Glitched starts
// are dropped silently; bad stop bits and overruns raise sticky flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err
);

  localparam logic [15:0] HALF_LOAD = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(BAUD_DIV - 1);

  rx_state_t   state;
  logic        rx_s;
  logic        rx_q;
  logic [1:0]  sync_valid;
  logic        armed;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;

  logic baud_zero;
  logic start_edge;
  logic stop_good;
  logic stop_bad;

  rx_sync #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (RX),
    .sync_out (rx_s)
  );

  // The synchronizer reads 1 for two cycles after reset regardless of the
  // line. If reset lands while the line is low (mid-frame), that artificial
  // high would look like a falling edge. The receiver only arms once a real
  // high has been seen, so a fresh start edge is required after reset.
  assign baud_zero  = (baud_cnt == 16'd0);
  assign start_edge = armed & rx_q & ~rx_s;
  assign stop_good  = (state == STOP) && baud_zero &&  rx_s;
  assign stop_bad   = (state == STOP) && baud_zero && !rx_s;

  // Edge-detect delay flop and post-reset arming.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q       <= 1'b1;
      sync_valid <= 2'b00;
      armed      <= 1'b0;
    end else begin
      rx_q       <= rx_s;
      sync_valid <= {sync_valid[0], 1'b1};
      armed      <= armed | (sync_valid[1] & rx_s);
    end
  end

  // Frame FSM with baud timer, bit counter and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge) begin
            state    <= START;
            baud_cnt <= HALF_LOAD;
          end
        end
        START: begin
          if (!baud_zero) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else if (rx_s) begin
            state <= IDLE;
          end else begin
            state    <= DATA;
            bit_cnt  <= 3'd0;
            baud_cnt <= FULL_LOAD;
          end
        end
        DATA: begin
          if (!baud_zero) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else begin
            shift    <= {rx_s, shift[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            baud_cnt <= FULL_LOAD;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (!baud_zero) baud_cnt <= baud_cnt - 16'd1;
          else            state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output byte and status flags; a flag being set wins over clr_rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data <= 8'h00;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else if (stop_good) begin
      rx_data <= shift;
      rdy     <= 1'b1;
      frm_err <= 1'b0;
      ovr_err <= rdy | (ovr_err & ~clr_rdy);
    end else if (stop_bad) begin
      frm_err <= 1'b1;
      if (clr_rdy) begin
        rdy     <= 1'b0;
        ovr_err <= 1'b0;
      end
    end else if (clr_rdy) begin
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a directed frame table, hand-written
// corner sequences, randomized frames against a frame-level model, and one
// full-rate frame on a second instance.
module tb_uart_rx;

  localparam int DIV_S = 16;
  localparam int DIV_F = 2604;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_line, rx_full;
  logic       clr_rdy, clr_full;
  logic [7:0] rx_data, rx_data_f;
  logic       rdy, frm_err, ovr_err;
  logic       rdy_f, frm_err_f, ovr_err_f;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_rx #(.BAUD_DIV(DIV_S)) dut (
    .clk(clk), .rst(rst), .RX(rx_line), .clr_rdy(clr_rdy),
    .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err), .ovr_err(ovr_err)
  );

  uart_rx #(.BAUD_DIV(DIV_F)) dut_full (
    .clk(clk), .rst(rst), .RX(rx_full), .clr_rdy(clr_full),
    .rx_data(rx_data_f), .rdy(rdy_f), .frm_err(frm_err_f), .ovr_err(ovr_err_f)
  );

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         clr_before;
    logic [7:0] exp_data;
    bit         exp_rdy;
    bit         exp_frm;
    bit         exp_ovr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_lat(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d cycles, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] d, input bit r,
                           input bit f, input bit o);
    check({name, ".data"}, {24'd0, rx_data}, {24'd0, d});
    check({name, ".rdy"},  {31'd0, rdy},     {31'd0, r});
    check({name, ".frm"},  {31'd0, frm_err}, {31'd0, f});
    check({name, ".ovr"},  {31'd0, ovr_err}, {31'd0, o});
  endtask

  // Drive one 8N1 frame, LSB first; starts and ends on a falling clock edge.
  task automatic send(input logic [7:0] d, input bit stop, input bit full);
    logic [9:0] bits;
    int         div;
    bits = {stop, d, 1'b0};
    div  = full ? DIV_F : DIV_S;
    for (int i = 0; i < 10; i++) begin
      if (full) rx_full = bits[i];
      else      rx_line = bits[i];
      repeat (div) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask

  // Count falling edges until rdy, bounded.
  task automatic measure(input bit full, input int bound, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(full ? rdy_f : rdy) && lat < bound);
  endtask

  vec_t vecs[6];
  int   lat;

  // Frame-level reference model.
  logic [7:0] m_data;
  bit         m_rdy, m_frm, m_ovr;

  initial begin
    vecs[0] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; rx_line = 1'b1; rx_full = 1'b1; clr_rdy = 1'b0; clr_full = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    idle(8);

    // Single byte with start-edge-to-rdy latency.
    fork
      send(8'h5A, 1'b1, 1'b0);
      measure(1'b0, 400, lat);
    join
    check_lat("latency_16", lat, 154, 156);
    check_out("single", 8'h5A, 1'b1, 1'b0, 1'b0);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    check("clr_next_cycle", {31'd0, rdy}, 32'd0);
    idle(4);

    // Directed frame table.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].clr_before) pulse_clr();
      send(vecs[i].data, vecs[i].stop_ok, 1'b0);
      check_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_rdy,
                vecs[i].exp_frm, vecs[i].exp_ovr);
      idle(vecs[i].stop_ok ? 2 : 20);
    end
    pulse_clr();

    // Glitch shorter than half a bit is dropped, next frame still decodes.
    rx_line = 1'b0;
    repeat (5) @(negedge clk);
    idle(200);
    check_out("glitch", 8'hC3, 1'b0, 1'b0, 1'b0);
    send(8'hC3, 1'b1, 1'b0);
    check_out("after_glitch", 8'hC3, 1'b1, 1'b0, 1'b0);
    idle(4);
    pulse_clr();

    // Framing error followed by a break: no further frames.
    send(8'hA5, 1'b0, 1'b0);
    repeat (40 * DIV_S) @(negedge clk);
    check_out("break", 8'hC3, 1'b0, 1'b1, 1'b0);
    idle(2 * DIV_S);
    send(8'h3C, 1'b1, 1'b0);
    check_out("after_break", 8'h3C, 1'b1, 1'b0, 1'b0);
    idle(4);
    pulse_clr();

    // Back-to-back overrun, then clear coinciding with completion.
    send(8'h01, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    check_out("overrun", 8'hFF, 1'b1, 1'b0, 1'b1);
    idle(DIV_S);
    fork
      send(8'h55, 1'b1, 1'b0);
      begin
        repeat (154) @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
      end
    join
    check_out("set_wins", 8'h55, 1'b1, 1'b0, 1'b1);
    idle(4);

    // Reset during data bit 4 of 8'h81.
    fork
      send(8'h81, 1'b1, 1'b0);
      begin
        repeat (88) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
      end
    join
    idle(200);
    check_out("no_frame_after_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h7E, 1'b1, 1'b0);
    check_out("after_reset", 8'h7E, 1'b1, 1'b0, 1'b0);
    idle(4);
    pulse_clr();

    // Randomized frames against the frame-level model.
    m_data = 8'h7E; m_rdy = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
    for (int i = 0; i < 30; i++) begin
      logic [7:0] d;
      bit         ok;
      int         gap;
      d   = 8'($urandom);
      ok  = ($urandom_range(0, 4) != 0);
      gap = ok ? $urandom_range(0, 20) : $urandom_range(20, 40);
      if ($urandom_range(0, 2) == 0) begin
        pulse_clr();
        m_rdy = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
      end
      send(d, ok, 1'b0);
      if (ok) begin
        if (m_rdy) m_ovr = 1'b1;
        m_data = d; m_rdy = 1'b1; m_frm = 1'b0;
      end else begin
        m_frm = 1'b1;
      end
      check_out($sformatf("rand%0d", i), m_data, m_rdy, m_frm, m_ovr);
      idle(gap);
    end

    // Full-rate frame on the 19200-baud instance.
    fork
      send(8'hB6, 1'b1, 1'b1);
      measure(1'b1, 30000, lat);
    join
    check_lat("latency_2604", lat, 24740, 24742);
    check("full.data", {24'd0, rx_data_f}, 32'h0000_00B6);
    check("full.frm",  {31'd0, frm_err_f}, 32'd0);
    check("full.ovr",  {31'd0, ovr_err_f}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
